// File: rtl/fnd_scan_reader_if.sv
// Bus bundle for fnd_scan_reader: sampled FND scan lines in, decoded frame out.
// err_count is present only when FND_ERR_COUNT_EN is defined.
interface fnd_scan_reader_if;
   logic [3:0]  fnd_com;
   logic [7:0]  fnd_data;
   logic [15:0] bcd_out;
   logic        frame_valid;
   logic        code_err;
`ifdef FND_ERR_COUNT_EN
   logic [7:0]  err_count;

   modport master (output fnd_com, fnd_data,
                   input  bcd_out, frame_valid, code_err, err_count);
   modport slave  (input  fnd_com, fnd_data,
                   output bcd_out, frame_valid, code_err, err_count);
`else
   modport master (output fnd_com, fnd_data,
                   input  bcd_out, frame_valid, code_err);
   modport slave  (input  fnd_com, fnd_data,
                   output bcd_out, frame_valid, code_err);
`endif
endinterface

// File: rtl/fnd_scan_reader.sv
// Reads a multiplexed 4-digit 7-segment scan and rebuilds the BCD frame.
// Optional FND_ERR_COUNT_EN adds a saturating 8-bit unknown-pattern counter.
module fnd_scan_reader #(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input logic               clk,
   input logic               reset_n,
   fnd_scan_reader_if.slave  bus
);

   localparam logic [3:0] STAB = 4'(STABLE_CYCLES);

   logic [3:0]       com_q, com_d;
   logic [7:0]       data_q, data_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [3:0][3:0]  shadow_q, shadow_d;
   logic [3:0]       cap_q, cap_d;
   logic [15:0]      bcd_q, bcd_d;
   logic             fv_q, fv_d;
   logic             ce_q, ce_d;

   logic             one_hot;
   logic [1:0]       idx;
   logic             same;
   logic             capture;
   logic             known;
   logic [3:0]       nib;
   logic [3:0]       cap_next;

   function automatic logic [4:0] decode(input logic [7:0] pat);
      case (pat)
         8'hC0: decode = {1'b1, 4'h0};
         8'hF9: decode = {1'b1, 4'h1};
         8'hA4: decode = {1'b1, 4'h2};
         8'hB0: decode = {1'b1, 4'h3};
         8'h99: decode = {1'b1, 4'h4};
         8'h92: decode = {1'b1, 4'h5};
         8'h82: decode = {1'b1, 4'h6};
         8'hF8: decode = {1'b1, 4'h7};
         8'h80: decode = {1'b1, 4'h8};
         8'h90: decode = {1'b1, 4'h9};
         8'h88: decode = {1'b1, 4'hA};
         8'h83: decode = {1'b1, 4'hB};
         8'hC6: decode = {1'b1, 4'hC};
         8'hA1: decode = {1'b1, 4'hD};
         8'h7F: decode = {1'b1, 4'hE};
         8'hFF: decode = {1'b1, 4'hF};
         default: decode = {1'b0, 4'h0};
      endcase
   endfunction

   always_comb begin
      com_d    = bus.fnd_com;
      data_d   = bus.fnd_data;
      one_hot  = 1'b1;
      idx      = 2'd0;
      case (com_q)
         4'hE: idx = 2'd0;
         4'hD: idx = 2'd1;
         4'hB: idx = 2'd2;
         4'h7: idx = 2'd3;
         default: one_hot = 1'b0;
      endcase

      // A cycle counts as stable when the sample stage reloads the value it already holds.
      same     = (com_d == com_q) && (data_d == data_q);
      cnt_d    = 4'd0;
      if (one_hot && same)
         cnt_d = (cnt_q == STAB) ? cnt_q : cnt_q + 4'd1;
      capture  = one_hot && same && (cnt_q == STAB - 4'd1);

      {known, nib} = decode(data_q);
      cap_next = cap_q | (4'b0001 << idx);

      shadow_d = shadow_q;
      cap_d    = cap_q;
      bcd_d    = bcd_q;
      fv_d     = 1'b0;
      ce_d     = 1'b0;
      if (capture) begin
         if (known) begin
            shadow_d[idx] = nib;
            if (cap_next == 4'hF) begin
               bcd_d = shadow_d;
               fv_d  = 1'b1;
               cap_d = 4'h0;
            end else begin
               cap_d = cap_next;
            end
         end else begin
            ce_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         com_q    <= 4'hF;
         data_q   <= 8'hFF;
         cnt_q    <= 4'd0;
         shadow_q <= '0;
         cap_q    <= 4'h0;
         bcd_q    <= 16'h0000;
         fv_q     <= 1'b0;
         ce_q     <= 1'b0;
      end else begin
         com_q    <= com_d;
         data_q   <= data_d;
         cnt_q    <= cnt_d;
         shadow_q <= shadow_d;
         cap_q    <= cap_d;
         bcd_q    <= bcd_d;
         fv_q     <= fv_d;
         ce_q     <= ce_d;
      end
   end

   assign bus.bcd_out     = bcd_q;
   assign bus.frame_valid = fv_q;
   assign bus.code_err    = ce_q;

`ifdef FND_ERR_COUNT_EN
   logic [7:0] errc_q, errc_d;

   // Counts alongside the code_err pulse so both update on the capture edge.
   always_comb begin
      errc_d = errc_q;
      if (ce_d && errc_q != 8'hFF)
         errc_d = errc_q + 8'd1;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) errc_q <= 8'h00;
      else          errc_q <= errc_d;
   end

   assign bus.err_count = errc_q;
`endif

endmodule
